// File: rtl/freq_generator_if.sv
// Control/status bundle of the phase-accumulator square-wave generator.
// The bench drives through master; the generator sits on slave.
interface freq_generator_if #(
  parameter int FREQ_W = 16
);
  logic              enable;
  logic              load;
  logic [FREQ_W-1:0] freq_set;
  logic              OUT;
  logic              rise;
  logic [FREQ_W-1:0] freq_active;
  logic              pending;

  modport master (
    output enable, load, freq_set,
    input  OUT, rise, freq_active, pending
  );

  modport slave (
    input  enable, load, freq_set,
    output OUT, rise, freq_active, pending
  );
endinterface

// File: rtl/freq_generator.sv
// Square-wave source with an exact long-run rate from a phase accumulator.
// Frequency changes made while running wait for the next rising edge of OUT.
module freq_generator #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int          FREQ_W = 16,
  parameter int          ACC_W  = 28
) (
  input  logic             CLK,
  input  logic             RESET,
  freq_generator_if.slave  bus
);
  typedef logic [ACC_W:0] sum_t;

  localparam sum_t LIM  = sum_t'(CLK_HZ);
  localparam sum_t HALF = sum_t'(CLK_HZ / 2);

  logic [ACC_W-1:0]  r_acc;
  logic              r_out;
  logic              r_rise;
  logic [FREQ_W-1:0] r_freq_active;
  logic [FREQ_W-1:0] r_pend;
  logic              r_pending;

  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_out_nxt;
  logic              w_rise_nxt;
  logic [FREQ_W-1:0] w_freq_nxt;
  logic [FREQ_W-1:0] w_pend_nxt;
  logic              w_pending_nxt;

  logic              w_running;
  sum_t              w_set_ext;
  logic [FREQ_W-1:0] w_fs;
  sum_t              w_step;
  sum_t              w_sum;
  logic              w_toggle;
  logic [ACC_W-1:0]  w_acc_adv;

  assign w_running = bus.enable && (r_freq_active != '0);

  // Compare at accumulator width: CLK_HZ/2 need not fit in FREQ_W bits.
  assign w_set_ext = sum_t'(bus.freq_set);
  assign w_fs      = (w_set_ext > HALF) ? FREQ_W'(HALF) : bus.freq_set;

  assign w_step    = sum_t'(r_freq_active) << 1;
  assign w_sum     = {1'b0, r_acc} + w_step;
  assign w_toggle  = (w_sum >= LIM);
  assign w_acc_adv = w_toggle ? ACC_W'(w_sum - LIM) : ACC_W'(w_sum);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_acc_nxt     = '0;
    w_out_nxt     = 1'b0;
    w_rise_nxt    = 1'b0;
    w_freq_nxt    = r_freq_active;
    w_pend_nxt    = r_pend;
    w_pending_nxt = r_pending;

    if (w_running) begin
      w_acc_nxt = w_acc_adv;
      w_out_nxt = r_out ^ w_toggle;
      if (w_toggle && !r_out) begin
        w_rise_nxt = 1'b1;
        if (r_pending) begin
          // New phase starts on this rising edge; a pending zero stops the output here.
          w_freq_nxt    = r_pend;
          w_pending_nxt = 1'b0;
          w_acc_nxt     = '0;
          if (r_pend == '0) begin
            w_out_nxt  = 1'b0;
            w_rise_nxt = 1'b0;
          end
        end
      end
      if (bus.load) begin
        w_pend_nxt    = w_fs;
        w_pending_nxt = 1'b1;
      end
    end else begin
      if (r_pending) begin
        w_freq_nxt    = r_pend;
        w_pending_nxt = 1'b0;
      end
      if (bus.load) begin
        w_freq_nxt    = w_fs;
        w_pending_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_acc         <= '0;
      r_out         <= 1'b0;
      r_rise        <= 1'b0;
      r_freq_active <= '0;
      r_pend        <= '0;
      r_pending     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      r_acc         <= w_acc_nxt;
      r_out         <= w_out_nxt;
      r_rise        <= w_rise_nxt;
      r_freq_active <= w_freq_nxt;
      r_pend        <= w_pend_nxt;
      r_pending     <= w_pending_nxt;
    end
  end

  assign bus.OUT         = r_out;
  assign bus.rise        = r_rise;
  assign bus.freq_active = r_freq_active;
  assign bus.pending     = r_pending;
endmodule

// File: tb/tb_freq_generator.sv
// Bench for freq_generator at CLK_HZ=100: a toggle-count model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_freq_generator;
  localparam int C  = 100;
  localparam int FW = 16;
  localparam int AW = 8;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  freq_generator_if #(.FREQ_W(FW)) bus ();

  freq_generator #(
    .CLK_HZ(C),
    .FREQ_W(FW),
    .ACC_W (AW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: within a phase of frequency f, the toggle count after k running cycles
  // is floor(2*f*k/C); OUT is the phase's starting level xor that count's parity.
  int     m_f = 0, m_pend = 0;
  longint m_k = 0, m_t0 = 0, m_t1 = 0;
  bit     m_out = 0, m_rise = 0, m_pending = 0, m_base = 0, m_lvl = 0;

  function automatic int sat(input int v);
    return (v > C / 2) ? C / 2 : v;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_f = 0; m_pend = 0; m_k = 0; m_out = 0; m_rise = 0; m_pending = 0; m_base = 0;
    end else if (bus.enable && m_f != 0) begin
      m_t0   = (m_k * 2 * m_f) / C;
      m_t1   = ((m_k + 1) * 2 * m_f) / C;
      m_lvl  = m_base ^ m_t1[0];
      m_rise = (m_t1 != m_t0) && m_lvl;
      m_out  = m_lvl;
      m_k    = (m_k + 1 == C) ? 0 : m_k + 1;
      if (m_rise && m_pending) begin
        m_pending = 0; m_f = m_pend; m_k = 0; m_base = 1;
        if (m_pend == 0) begin
          m_out = 0; m_rise = 0; m_base = 0;
        end
      end
      if (bus.load) begin
        m_pend = sat(int'(bus.freq_set)); m_pending = 1;
      end
    end else begin
      m_out = 0; m_rise = 0; m_k = 0; m_base = 0;
      if (m_pending) begin
        m_f = m_pend; m_pending = 0;
      end
      if (bus.load) begin
        m_f = sat(int'(bus.freq_set)); m_pending = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_out",     32'(bus.OUT),         32'(m_out));
      check("model_rise",    32'(bus.rise),        32'(m_rise));
      check("model_freq",    32'(bus.freq_active), 32'(m_f));
      check("model_pending", 32'(bus.pending),     32'(m_pending));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_load(input int v);
    @(negedge CLK);
    bus.freq_set = FW'(v);
    bus.load     = 1'b1;
    @(negedge CLK);
    bus.load     = 1'b0;
  endtask

  task automatic wait_rise(input int max, output int cycles);
    cycles = 0;
    while (cycles < max) begin
      @(negedge CLK);
      cycles++;
      if (bus.rise === 1'b1) break;
    end
  endtask

  task automatic count_cycles(input int n, output int rises, output int highs);
    rises = 0;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (bus.rise === 1'b1) rises++;
      if (bus.OUT === 1'b1) highs++;
    end
  endtask

  initial begin
    int c, r, h, prev, sp;
    bus.enable   = 1'b1;
    bus.load     = 1'b0;
    bus.freq_set = '0;
    tick(3);
    RESET  = 1'b1;
    chk_en = 1'b1;

    check("reset_out",     32'(bus.OUT),         0);
    check("reset_rise",    32'(bus.rise),        0);
    check("reset_freq",    32'(bus.freq_active), 0);
    check("reset_pending", 32'(bus.pending),     0);

    // Fixed frequency 10 from idle.
    do_load(10);
    check("fixed_freq", 32'(bus.freq_active), 10);
    wait_rise(20, c);
    check("fixed_latency", 32'(c), 5);
    count_cycles(100, r, h);
    check("fixed_rises_100", 32'(r), 10);
    check("fixed_high_100",  32'(h), 50);

    // Asynchronous reset while OUT is high.
    wait_rise(20, c);
    @(posedge CLK);
    #2;
    check("pre_reset_out", 32'(bus.OUT), 1);
    RESET = 1'b0;
    #1;
    check("async_out",     32'(bus.OUT),         0);
    check("async_rise",    32'(bus.rise),        0);
    check("async_freq",    32'(bus.freq_active), 0);
    check("async_pending", 32'(bus.pending),     0);
    @(negedge CLK);
    RESET = 1'b1;
    count_cycles(20, r, h);
    check("post_reset_rises", 32'(r), 0);
    check("post_reset_high",  32'(h), 0);

    // Saturation: 80 clamps to 50, OUT toggles every cycle.
    do_load(80);
    check("sat_freq", 32'(bus.freq_active), 50);
    wait_rise(5, c);
    check("sat_latency", 32'(c), 1);
    count_cycles(10, r, h);
    check("sat_rises", 32'(r), 5);
    check("sat_high",  32'(h), 5);

    // Fractional frequency 3, loaded while parked.
    bus.enable = 1'b0;
    do_load(3);
    check("frac_freq", 32'(bus.freq_active), 3);
    bus.enable = 1'b1;
    r = 0;
    prev = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge CLK);
      if (bus.rise === 1'b1) begin
        r++;
        if (prev >= 0) begin
          sp = i - prev;
          check("frac_spacing_33_34", 32'(sp == 33 || sp == 34), 1);
        end
        prev = i;
      end
    end
    check("frac_rises_1000", 32'(r), 30);

    // Deferred change: 25 then 20 loaded mid-period, 20 applied at the next rise.
    bus.enable = 1'b0;
    do_load(10);
    bus.enable = 1'b1;
    wait_rise(30, c);
    check("defer_start_latency", 32'(c), 5);
    tick(2);
    do_load(25);
    check("defer_pending_a", 32'(bus.pending),     1);
    check("defer_freq_hold", 32'(bus.freq_active), 10);
    tick(1);
    do_load(20);
    check("defer_pending_b", 32'(bus.pending), 1);
    wait_rise(20, c);
    check("defer_rise_on_schedule", 32'(c), 3);
    check("defer_freq_applied", 32'(bus.freq_active), 20);
    check("defer_pending_clear", 32'(bus.pending),    0);
    wait_rise(20, c);
    check("defer_next_rise", 32'(c), 5);

    // Load sampled on the rising edge itself waits for the following rise.
    bus.enable = 1'b0;
    do_load(10);
    bus.enable = 1'b1;
    wait_rise(30, c);
    tick(8);
    do_load(25);
    check("coinc_rise",    32'(bus.rise),        1);
    check("coinc_freq",    32'(bus.freq_active), 10);
    check("coinc_pending", 32'(bus.pending),     1);
    wait_rise(30, c);
    check("coinc_next_rise", 32'(c), 10);
    check("coinc_applied",   32'(bus.freq_active), 25);

    // Pending value is applied immediately when parked.
    tick(2);
    do_load(30);
    check("park_pending", 32'(bus.pending), 1);
    bus.enable = 1'b0;
    tick(1);
    check("park_freq",    32'(bus.freq_active), 30);
    check("park_pending_clear", 32'(bus.pending), 0);
    check("park_out",     32'(bus.OUT),         0);

    // Enable gating for 7 cycles at f=10.
    do_load(10);
    bus.enable = 1'b1;
    wait_rise(30, c);
    bus.enable = 1'b0;
    count_cycles(7, r, h);
    check("gate_rises", 32'(r), 0);
    check("gate_high",  32'(h), 0);
    bus.enable = 1'b1;
    wait_rise(30, c);
    check("gate_restart_latency", 32'(c), 5);

    // Loading zero stops the output at the next rise.
    tick(2);
    do_load(0);
    check("zero_pending",   32'(bus.pending),     1);
    check("zero_freq_hold", 32'(bus.freq_active), 10);
    count_cycles(30, r, h);
    check("zero_rises",   32'(r),               0);
    check("zero_freq",    32'(bus.freq_active), 0);
    check("zero_pending_clear", 32'(bus.pending), 0);
    check("zero_out",     32'(bus.OUT),         0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/freq_generator.md
# freq_generator

Programmable square-wave source clocked from the 100 MHz system clock. It produces an output whose average frequency equals a requested value in Hz; the frequency counter is the measuring side of this signal. Frequency is synthesized with a phase accumulator, so the long-run rate is exact. Frequency changes requested while the output is running are deferred to the next rising edge, so no period is ever truncated.

## Interface
- `CLK_HZ`, default 100000000: CLK frequency in Hz. Benches may override it with a small value.
- `FREQ_W`, default 16: width of the frequency words.
- `ACC_W`, default 28: accumulator width. Must satisfy 2^ACC_W > 2*CLK_HZ.
- `CLK` input, 1 bit: system clock. All state changes on the rising edge.
- `RESET` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: 1 runs the generator; 0 parks it.
- `load` input, 1 bit: one-cycle strobe that samples `freq_set`.
- `freq_set` input, FREQ_W bits: requested frequency in Hz.
- `OUT` output, 1 bit: generated square wave (registered).
- `rise` output, 1 bit: one-cycle pulse in the same cycle that `OUT` goes 0→1.
- `freq_active` output, FREQ_W bits: frequency currently being generated.
- `pending` output, 1 bit: a loaded value is waiting for the next rising edge.

## Operation
- **Saturation:** `fs = min(freq_set, CLK_HZ/2)`, using integer division. The result is stored in the pending register or in `freq_active`.
- **Step:** `step = 2*freq_active`, computed zero-extended to ACC_W.
- **Running** means `enable==1` and `freq_active!=0`. Each cycle:
  - `sum = acc + step`.
  - If `sum >= CLK_HZ`: `acc <= sum - CLK_HZ` and `OUT` toggles.
  - Otherwise `acc <= sum`.
  - `rise` = 1 in the cycle `OUT` becomes 1.
- **Exact rate:** over any CLK_HZ consecutive running cycles with a fixed frequency f, exactly 2f toggles occur.
- **Idle** means `enable==0` or `freq_active==0`. In idle, `acc <= 0`, `OUT <= 0` and `rise = 0`.
- **Load while idle:** `freq_active <= fs`, `acc <= 0`, `pending` stays 0. The value takes effect at the next edge.
- **Load while running:** `pend <= fs` and `pending <= 1`. A new load while `pending==1` overwrites `pend` (last value wins).
- **Apply:** on the edge where a running `OUT` goes 0→1 and `pending==1`:
  - `freq_active <= pend`, `acc <= 0`, `pending <= 0`.
  - The new frequency's phase starts at that rising edge.
- **Load coincident with a rise:** the value is captured and applied at the following rise, not the current one.
- **Pending while parked:** if `enable` drops or `freq_active` is 0 while `pending==1`, the pending value is applied at the next edge. `pending` then clears and the block goes idle with `OUT = 0`.
- **Loading zero:** a loaded 0 is a legal pending value. When applied, the generator stops with `OUT = 0` at that same edge, so no rise is issued.
- **Enable low:** parks the generator. On re-enable, operation restarts from `acc = 0` with `OUT = 0`.

## Timing
- **Reset:** asserted `RESET==0` immediately forces `OUT=0`, `rise=0`, `freq_active=0`, `pending=0`, `pend=0` and `acc=0`. Release is synchronous to CLK as far as bench stimulus is concerned.
- **Latency from idle:**
  - `load` in cycle n updates `freq_active` at edge n+1.
  - With step s, the first toggle happens at edge n+1+ceil(CLK_HZ/s).
- **Maximum frequency:** f = CLK_HZ/2 toggles every cycle, giving a 2-cycle period.
- **Timing alignment:** `rise` and `OUT` are registered and change on the same edge. There is no combinational path from inputs to outputs.
- **Widths:** `sum` has ACC_W+1 bits, so the addition cannot overflow. The comparison and subtraction are unsigned.

## Test plan
- **Reset mid-run:** with CLK_HZ=100, f=10, assert `RESET`=0. Outputs must go to 0 without waiting for a CLK edge; after release, `OUT` stays 0 until a load.
- **Fixed frequency:** with CLK_HZ=100, load 10 from idle.
  - `OUT` toggles every 5 cycles (period 10).
  - `rise` is high for 1 cycle in every 10.
  - Exactly 10 rises occur in 100 cycles.
- **Fractional frequency:** with CLK_HZ=100, load 3.
  - Over 1000 running cycles exactly 30 rises occur.
  - Individual rise-to-rise spacing is 33 or 34 cycles.
- **Saturation:** with CLK_HZ=100, load 80. `freq_active` reads 50 and `OUT` alternates every cycle.
- **Deferred change:** with CLK_HZ=100 running at f=10, issue load 25 mid-period and then load 20 before the next rise.
  - `pending`=1 until that rise.
  - `freq_active` becomes 20 at the rise.
  - The following rise occurs 5 cycles later.
- **Enable gating and zero load:**
  - With CLK_HZ=100 at f=10, drop `enable` for 7 cycles: `OUT`=0 and there are no rises. On re-enable the first toggle comes 5 cycles later.
  - Loading 0 while running stops `OUT` at the next rise: that rise does not occur, and `OUT` stays 0.
